// File: rtl/mem_cache_controller_if.sv
// mem_cache_controller_if: bundles the MEM-stage request/response signals and
// the SRAM-controller request/response signals seen by the cache controller.
// The slave modport is the controller's view; master is the surrounding
// pipeline/SRAM side.
interface mem_cache_controller_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic [31:0] DATA;
  logic        ready;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, sram_rdata, sram_ready,
    output DATA, ready, sram_r_en, sram_w_en, sram_addr, sram_wdata,
           hit_count, miss_count
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, sram_rdata, sram_ready,
    input  DATA, ready, sram_r_en, sram_w_en, sram_addr, sram_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/mem_cache_controller.sv
// mem_cache_controller: direct-mapped, write-through, no-write-allocate cache
// between the MEM stage and the SRAM controller, one 32-bit word per line.
// Loads that hit complete in the request cycle; every store and every read
// miss goes to SRAM while ready is held low.
// Optional feature macro: CACHE_STATS_EN enables saturating hit/miss counters;
// when undefined the counters are tied to zero.
module mem_cache_controller #(
  parameter int          SET_BITS  = 6,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_cache_controller_if.slave bus
);

  localparam int LINES = 1 << SET_BITS;
  localparam int TAG_W = 17 - SET_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [LINES-1:0]     valid_r;
  logic [TAG_W-1:0]     tag_r  [LINES];
  logic [31:0]          data_r [LINES];

  logic [31:0]          adr_s;
  logic [SET_BITS-1:0]  index_s;
  logic [TAG_W-1:0]     tag_s;
  logic                 hit_s;
  logic                 fill_s;
  logic                 upd_s;
  logic                 cnt_hit_s;
  logic                 cnt_miss_s;
  logic                 ready_s;
  logic [31:0]          data_s;
  logic                 unused_addr_bits_s;

  // The byte offset and the address bits above the tag do not take part in lookup.
  assign adr_s              = bus.ALU_Res - BASE_ADDR;
  assign index_s            = adr_s[SET_BITS+1:2];
  assign tag_s              = adr_s[18:SET_BITS+2];
  assign unused_addr_bits_s = ^{adr_s[31:19], adr_s[1:0]};
  assign hit_s              = valid_r[index_s] && (tag_r[index_s] == tag_s);

  assign bus.sram_addr  = bus.ALU_Res;
  assign bus.sram_wdata = bus.Val_Rm;
  assign bus.ready      = ready_s;
  assign bus.DATA       = data_s;
  // The SRAM enables decode straight from the state register, so they drop
  // the cycle after completion or after a reset.
  assign bus.sram_r_en  = (state_r == RD_MISS);
  assign bus.sram_w_en  = (state_r == WR_THRU);

  // State register; reset abandons any outstanding SRAM transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, handshake and load-data decode.
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = 1'b1;
    data_s      = 32'd0;
    fill_s      = 1'b0;
    upd_s       = 1'b0;
    cnt_hit_s   = 1'b0;
    cnt_miss_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.MEM_W_EN) begin
          // Stores win over a simultaneous load; the load is dropped.
          ready_s     = 1'b0;
          state_nxt_s = WR_THRU;
        end else if (bus.MEM_R_EN) begin
          if (hit_s) begin
            data_s    = data_r[index_s];
            cnt_hit_s = 1'b1;
          end else begin
            ready_s     = 1'b0;
            cnt_miss_s  = 1'b1;
            state_nxt_s = RD_MISS;
          end
        end else begin
          ready_s = 1'b1;
        end
      end
      RD_MISS: begin
        if (bus.sram_ready) begin
          data_s      = bus.sram_rdata;
          fill_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          ready_s = 1'b0;
        end
      end
      WR_THRU: begin
        if (bus.sram_ready) begin
          upd_s       = hit_s;
          state_nxt_s = IDLE;
        end else begin
          ready_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Valid bits: cleared on reset, set when a read miss fills its line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (fill_s) begin
      valid_r[index_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag/data storage: fill on read-miss completion, refresh data on a write hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_s) begin
        tag_r[index_s]  <= tag_s;
        data_r[index_s] <= bus.sram_rdata;
      end else if (upd_s) begin
        data_r[index_s] <= bus.Val_Rm;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_r;
  logic [15:0] miss_cnt_r;

  // Saturating read hit/miss counters, bumped once per load at IDLE decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= 16'd0;
      miss_cnt_r <= 16'd0;
    end else begin
      if (cnt_hit_s && (hit_cnt_r != 16'hFFFF)) begin
        hit_cnt_r <= hit_cnt_r + 16'd1;
      end
      if (cnt_miss_s && (miss_cnt_r != 16'hFFFF)) begin
        miss_cnt_r <= miss_cnt_r + 16'd1;
      end
    end
  end

  assign bus.hit_count  = hit_cnt_r;
  assign bus.miss_count = miss_cnt_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = cnt_hit_s ^ cnt_miss_s;
  assign bus.hit_count  = 16'd0;
  assign bus.miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_cache_controller.sv
// tb_mem_cache_controller: directed stimulus against a transaction-level
// cache model; every cycle the DUT outputs are compared with the model, and
// the directed sequences also pin latencies and data to literal values.
module tb_mem_cache_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_cache_controller_if bus ();

  mem_cache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_pend: 0 = no SRAM transaction outstanding, 1 = read fill pending,
  // 2 = store pending at the SRAM controller.
  int          m_pend;
  logic        m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_data  [64];
  int          m_hits;
  int          m_misses;

  function automatic int unsigned line_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (off / 32'd4) % 32'd64;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (off / 32'd256) % 32'd2048;
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
  endfunction

  initial begin
    m_pend = 0; m_hits = 0; m_misses = 0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_pend   <= 0;
      m_hits   <= 0;
      m_misses <= 0;
      for (int i = 0; i < 64; i++) m_valid[i] <= 1'b0;
    end else if (m_pend == 0) begin
      if (bus.MEM_W_EN) m_pend <= 2;
      else if (bus.MEM_R_EN && model_hit(bus.ALU_Res)) m_hits <= m_hits + 1;
      else if (bus.MEM_R_EN) begin
        m_misses <= m_misses + 1;
        m_pend   <= 1;
      end
    end else if (bus.sram_ready) begin
      if (m_pend == 1) begin
        m_valid[line_of(bus.ALU_Res)] <= 1'b1;
        m_tag[line_of(bus.ALU_Res)]   <= tag_of(bus.ALU_Res);
        m_data[line_of(bus.ALU_Res)]  <= bus.sram_rdata;
      end else if (model_hit(bus.ALU_Res)) begin
        m_data[line_of(bus.ALU_Res)]  <= bus.Val_Rm;
      end
      m_pend <= 0;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic        e_ready;
  logic        e_ren;
  logic        e_wen;
  logic [31:0] e_data;
  logic [15:0] e_hc;
  logic [15:0] e_mc;

  always @(negedge clk) begin
    e_ren  = (m_pend == 1);
    e_wen  = (m_pend == 2);
    e_data = 32'd0;
    if (m_pend == 0) begin
      e_ready = !(bus.MEM_W_EN || (bus.MEM_R_EN && !model_hit(bus.ALU_Res)));
      if (bus.MEM_R_EN && model_hit(bus.ALU_Res)) e_data = m_data[line_of(bus.ALU_Res)];
    end else begin
      e_ready = bus.sram_ready;
      e_data  = bus.sram_rdata;
    end
    chk("ready", {31'd0, bus.ready}, {31'd0, e_ready});
    chk("sram_r_en", {31'd0, bus.sram_r_en}, {31'd0, e_ren});
    chk("sram_w_en", {31'd0, bus.sram_w_en}, {31'd0, e_wen});
    chk("sram_addr", bus.sram_addr, bus.ALU_Res);
    chk("sram_wdata", bus.sram_wdata, bus.Val_Rm);
    if (bus.ready && bus.MEM_R_EN && !bus.MEM_W_EN) chk("DATA", bus.DATA, e_data);
`ifdef CACHE_STATS_EN
    e_hc = (m_hits > 65535) ? 16'hFFFF : m_hits[15:0];
    e_mc = (m_misses > 65535) ? 16'hFFFF : m_misses[15:0];
`else
    e_hc = 16'd0;
    e_mc = 16'd0;
`endif
    chk("hit_count", {16'd0, bus.hit_count}, {16'd0, e_hc});
    chk("miss_count", {16'd0, bus.miss_count}, {16'd0, e_mc});
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.sram_ready = 1'b0;
    bus.sram_rdata = 32'd0;
  endtask

  // Called #1 after a rising edge. Presents one access, answers from SRAM
  // n cycles after the first SRAM-request cycle, and returns the number of
  // ready-low cycles, the load data and whether an SRAM read was seen.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int n,
                        output int stalls, output logic [31:0] got, output logic saw_r);
    bus.MEM_R_EN   = rd;
    bus.MEM_W_EN   = wr;
    bus.ALU_Res    = addr;
    bus.Val_Rm     = wd;
    bus.sram_rdata = rdata;
    bus.sram_ready = 1'b0;
    stalls = 0;
    got    = 32'd0;
    saw_r  = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.sram_r_en) saw_r = 1'b1;
      if (bus.ready) begin
        got = bus.DATA;
        break;
      end
      stalls++;
      if (k == 199) chk("timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      bus.sram_ready = (stalls == n + 1);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int          st;
  logic [31:0] d;
  logic        sr;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.ALU_Res = 32'd1024;
    bus.Val_Rm  = 32'd0;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_DATA", bus.DATA, 32'd0);
    chk("rst_r_en", {31'd0, bus.sram_r_en}, 32'd0);
    chk("rst_w_en", {31'd0, bus.sram_w_en}, 32'd0);
    chk("rst_hits", {16'd0, bus.hit_count}, 32'd0);
    @(posedge clk); #1;

    // Cold read: 1 + 5 stall cycles.
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, 5, st, d, sr);
    chk("cold_stalls", st, 32'd6);
    chk("cold_data", d, 32'hDEADBEEF);
    chk("cold_sram_rd", {31'd0, sr}, 32'd1);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h0, 3, st, d, sr);
    chk("rehit_stalls", st, 32'd0);
    chk("rehit_data", d, 32'hDEADBEEF);
    chk("rehit_no_sram", {31'd0, sr}, 32'd0);

    // Write hit updates the line.
    access(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'h0, 3, st, d, sr);
    chk("wr_stalls", st, 32'd4);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h0, 3, st, d, sr);
    chk("wrhit_stalls", st, 32'd0);
    chk("wrhit_data", d, 32'h12345678);
    chk("wrhit_no_sram", {31'd0, sr}, 32'd0);

    // Write miss does not allocate.
    access(1'b0, 1'b1, 32'd1028, 32'hAAAA5555, 32'h0, 2, st, d, sr);
    chk("wrmiss_stalls", st, 32'd3);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 32'h0BADF00D, 1, st, d, sr);
    chk("noalloc_stalls", st, 32'd2);
    chk("noalloc_sram_rd", {31'd0, sr}, 32'd1);
    chk("noalloc_data", d, 32'h0BADF00D);

    // Conflict on index 0.
    access(1'b1, 1'b0, 32'd1280, 32'd0, 32'h11112222, 2, st, d, sr);
    chk("conf1_stalls", st, 32'd3);
    chk("conf1_data", d, 32'h11112222);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h33334444, 1, st, d, sr);
    chk("conf2_stalls", st, 32'd2);
    chk("conf2_data", d, 32'h33334444);

    // Stray sram_ready in IDLE is ignored.
    bus.sram_ready = 1'b1;
    @(posedge clk); #1;
    bus.sram_ready = 1'b0;
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h0, 1, st, d, sr);
    chk("stray_stalls", st, 32'd0);
    chk("stray_data", d, 32'h33334444);

    // Simultaneous load and store: store wins.
    access(1'b1, 1'b1, 32'd1024, 32'h55556666, 32'h0, 1, st, d, sr);
    chk("rw_stalls", st, 32'd2);
    chk("rw_no_sram_rd", {31'd0, sr}, 32'd0);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h0, 1, st, d, sr);
    chk("rw_data", d, 32'h55556666);

    // Back-to-back: fill then immediate hit.
    access(1'b1, 1'b0, 32'd1032, 32'd0, 32'hCAFEF00D, 1, st, d, sr);
    access(1'b1, 1'b0, 32'd1032, 32'd0, 32'h0, 1, st, d, sr);
    chk("b2b_stalls", st, 32'd0);
    chk("b2b_data", d, 32'hCAFEF00D);

    // Reset in the third RD_MISS cycle.
    bus.MEM_R_EN   = 1'b1;
    bus.ALU_Res    = 32'd1536;
    bus.sram_rdata = 32'h77778888;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("mid_rst_r_en", {31'd0, bus.sram_r_en}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1536, 32'd0, 32'h77778888, 1, st, d, sr);
    chk("mid_rst_miss", st, 32'd2);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h9999AAAA, 1, st, d, sr);
    chk("inval_miss", st, 32'd2);
    chk("inval_data", d, 32'h9999AAAA);

    // Statistics: miss, hit, hit.
    do_reset();
    access(1'b1, 1'b0, 32'd2048, 32'd0, 32'h01020304, 1, st, d, sr);
    access(1'b1, 1'b0, 32'd2048, 32'd0, 32'h0, 1, st, d, sr);
    access(1'b1, 1'b0, 32'd2048, 32'd0, 32'h0, 1, st, d, sr);
    @(negedge clk);
`ifdef CACHE_STATS_EN
    chk("stats_hits", {16'd0, bus.hit_count}, 32'd2);
    chk("stats_miss", {16'd0, bus.miss_count}, 32'd1);
`else
    chk("stats_hits", {16'd0, bus.hit_count}, 32'd0);
    chk("stats_miss", {16'd0, bus.miss_count}, 32'd0);
`endif
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
